grf_wr_arbiter: RTL and testbench

- Shares the general register file's single write port between two writers.
  - Requester 0 is the pipeline writeback stage; it has priority.
  - Requester 1 is the multi-cycle mult/div unit; it is buffered in a small FIFO.
- Drives the register file's write-enable, address, data and pc lines from a registered output stage.
- Reports per-register "write pending" flags so the hazard unit can stall readers.

---
 rtl/grf_wr_arbiter_if.sv | 41 ++++
 rtl/grf_wr_arbiter.sv | 150 +++++++++++++++
 tb/tb_grf_wr_arbiter.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/grf_wr_arbiter_if.sv
// Bundles the two writer handshakes, the register-file write lines and the hazard
// query ports of grf_wr_arbiter. master = requesters/consumers, slave = arbiter.
interface grf_wr_arbiter_if #(
    parameter int FIFO_DEPTH = 2
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic          r0_valid;
    logic          r0_ready;
    logic [4:0]    r0_addr;
    logic [31:0]   r0_data;
    logic [31:0]   r0_pc;
    logic          r1_valid;
    logic          r1_ready;
    logic [4:0]    r1_addr;
    logic [31:0]   r1_data;
    logic [31:0]   r1_pc;
    logic          RFWr;
    logic [4:0]    A3;
    logic [31:0]   WD;
    logic [31:0]   wpc;
    logic [4:0]    q1_addr;
    logic [4:0]    q2_addr;
    logic          q1_busy;
    logic          q2_busy;
    logic [CW-1:0] fifo_cnt;

    modport master (
        output r0_valid, r0_addr, r0_data, r0_pc,
        output r1_valid, r1_addr, r1_data, r1_pc,
        output q1_addr, q2_addr,
        input  r0_ready, r1_ready, RFWr, A3, WD, wpc, q1_busy, q2_busy, fifo_cnt
    );

    modport slave (
        input  r0_valid, r0_addr, r0_data, r0_pc,
        input  r1_valid, r1_addr, r1_data, r1_pc,
        input  q1_addr, q2_addr,
        output r0_ready, r1_ready, RFWr, A3, WD, wpc, q1_busy, q2_busy, fifo_cnt
    );
endinterface

// File: rtl/grf_wr_arbiter.sv
// Register-file write-port arbiter: writeback (r0) has priority, mult/div (r1) is queued
// and forced through after STARVE_MAX denials. Define GRF_WR_TRACE_EN for a write trace.
module grf_wr_arbiter #(
    parameter int FIFO_DEPTH = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    grf_wr_arbiter_if.slave bus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = $clog2(STARVE_MAX + 1);

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
        logic [31:0] pc;
    } entry_t;

    entry_t        fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic [SW-1:0] starve_reg, starve_next;
    logic          rfwr_reg, rfwr_next;
    logic [4:0]    a3_reg, a3_next;
    logic [31:0]   wd_reg, wd_next;
    logic [31:0]   wpc_reg, wpc_next;

    logic   fifo_ne, force_grant, grant_fifo, grant_r0, enq, wr_fire;
    entry_t gnt_entry;

    assign fifo_ne     = (cnt_reg != '0);
    assign force_grant = (starve_reg == SW'(STARVE_MAX)) && fifo_ne;
    assign grant_fifo  = force_grant || (!bus.r0_valid && fifo_ne);
    assign grant_r0    = !force_grant && bus.r0_valid;
    // Full means not ready even if the head leaves this cycle: no bypass path.
    assign enq         = bus.r1_valid && (cnt_reg != CW'(FIFO_DEPTH));

    always_comb begin
        gnt_entry = '{addr: bus.r0_addr, data: bus.r0_data, pc: bus.r0_pc};
        if (grant_fifo) begin
            gnt_entry = fifo_mem[rd_ptr_reg];
        end
    end

    // Writes to $0 are consumed silently and leave the address/data lines untouched.
    assign wr_fire = (grant_fifo || grant_r0) && (gnt_entry.addr != 5'd0);

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        cnt_next    = cnt_reg;
        starve_next = '0;
        rfwr_next   = wr_fire;
        a3_next     = a3_reg;
        wd_next     = wd_reg;
        wpc_next    = wpc_reg;
        if (enq) begin
            wr_ptr_next = wr_ptr_reg + PW'(1);
        end
        if (grant_fifo) begin
            rd_ptr_next = rd_ptr_reg + PW'(1);
        end
        if (enq && !grant_fifo) begin
            cnt_next = cnt_reg + CW'(1);
        end else if (!enq && grant_fifo) begin
            cnt_next = cnt_reg - CW'(1);
        end
        if (fifo_ne && !grant_fifo) begin
            starve_next = (starve_reg == SW'(STARVE_MAX)) ? starve_reg : starve_reg + SW'(1);
        end
        if (wr_fire) begin
            a3_next  = gnt_entry.addr;
            wd_next  = gnt_entry.data;
            wpc_next = gnt_entry.pc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            cnt_reg    <= '0;
            starve_reg <= '0;
            rfwr_reg   <= 1'b0;
            a3_reg     <= '0;
            wd_reg     <= '0;
            wpc_reg    <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            cnt_reg    <= cnt_next;
            starve_reg <= starve_next;
            rfwr_reg   <= rfwr_next;
            a3_reg     <= a3_next;
            wd_reg     <= wd_next;
            wpc_reg    <= wpc_next;
        end
    end

    // Storage needs no reset: occupancy is tracked by the pointers and count alone.
    always_ff @(posedge clk) begin
        if (rst_n && enq) begin
            fifo_mem[wr_ptr_reg] <= '{addr: bus.r1_addr, data: bus.r1_data, pc: bus.r1_pc};
        end
    end

    logic [FIFO_DEPTH-1:0] q1_hit, q2_hit;

    generate
        for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_entry
            logic [PW-1:0] offs;
            logic          live;
            assign offs       = PW'(gi) - rd_ptr_reg;
            assign live       = ({1'b0, offs} < cnt_reg);
            assign q1_hit[gi] = live && (fifo_mem[gi].addr == bus.q1_addr);
            assign q2_hit[gi] = live && (fifo_mem[gi].addr == bus.q2_addr);
        end
    endgenerate

    assign bus.q1_busy  = (bus.q1_addr != 5'd0) &&
                          ((|q1_hit) || (rfwr_reg && (a3_reg == bus.q1_addr)));
    assign bus.q2_busy  = (bus.q2_addr != 5'd0) &&
                          ((|q2_hit) || (rfwr_reg && (a3_reg == bus.q2_addr)));
    assign bus.r0_ready = !force_grant;
    assign bus.r1_ready = (cnt_reg != CW'(FIFO_DEPTH));
    assign bus.RFWr     = rfwr_reg;
    assign bus.A3       = a3_reg;
    assign bus.WD       = wd_reg;
    assign bus.wpc      = wpc_reg;
    assign bus.fifo_cnt = cnt_reg;

`ifdef GRF_WR_TRACE_EN
    always @(posedge clk) begin
        if (rst_n) begin
            if (wr_fire) begin
                $display("%0t@%h: $%0d <= %h src=%0d", $time, gnt_entry.pc, gnt_entry.addr,
                         gnt_entry.data, grant_fifo ? 1 : 0);
            end
            if (force_grant) begin
                $display("%0t starve: forcing queued write to $%0d", $time, gnt_entry.addr);
            end
        end
    end
`else
`endif

endmodule

// File: tb/tb_grf_wr_arbiter.sv
// Directed plus randomized bench for grf_wr_arbiter; a queue-based model of the
// arbitration rules predicts every output once per cycle.
module tb_grf_wr_arbiter;
    localparam int FIFO_DEPTH = 2;
    localparam int STARVE_MAX = 4;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
        logic [31:0] pc;
    } ent_t;

    logic clk;
    logic rst_n;

    grf_wr_arbiter_if #(.FIFO_DEPTH(FIFO_DEPTH)) bus ();

    grf_wr_arbiter #(.FIFO_DEPTH(FIFO_DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    ent_t        mq[$];
    int          m_starve;
    logic        m_rfwr;
    logic [4:0]  m_a3;
    logic [31:0] m_wd;
    logic [31:0] m_wpc;
    bit          last_push;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit busy_m(input logic [4:0] a);
        if (a == 5'd0) return 1'b0;
        foreach (mq[i]) if (mq[i].addr == a) return 1'b1;
        return m_rfwr && (m_a3 == a);
    endfunction

    task automatic model_clear();
        mq.delete();
        m_starve = 0;
        m_rfwr   = 1'b0;
        m_a3     = '0;
        m_wd     = '0;
        m_wpc    = '0;
    endtask

    task automatic chk_all(input bit exp_r0_ready);
        chk("RFWr", 32'(bus.RFWr), 32'(m_rfwr));
        chk("A3", 32'(bus.A3), 32'(m_a3));
        chk("WD", bus.WD, m_wd);
        chk("wpc", bus.wpc, m_wpc);
        chk("fifo_cnt", 32'(bus.fifo_cnt), 32'(mq.size()));
        chk("r0_ready", 32'(bus.r0_ready), 32'(exp_r0_ready));
        chk("r1_ready", 32'(bus.r1_ready), 32'(mq.size() != FIFO_DEPTH));
        chk("q1_busy", 32'(bus.q1_busy), 32'(busy_m(bus.q1_addr)));
        chk("q2_busy", 32'(bus.q2_busy), 32'(busy_m(bus.q2_addr)));
    endtask

    // Called shortly after a falling edge; returns shortly after the next falling edge.
    task automatic cycle(input bit r0v, input logic [4:0] r0a, input logic [31:0] r0d,
                         input logic [31:0] r0p, input bit r1v, input logic [4:0] r1a,
                         input logic [31:0] r1d, input logic [31:0] r1p,
                         input logic [4:0] qa, input logic [4:0] qb);
        bit   frc, push;
        int   src;
        ent_t g;
        bus.r0_valid = r0v; bus.r0_addr = r0a; bus.r0_data = r0d; bus.r0_pc = r0p;
        bus.r1_valid = r1v; bus.r1_addr = r1a; bus.r1_data = r1d; bus.r1_pc = r1p;
        bus.q1_addr  = qa;  bus.q2_addr = qb;
        #1;
        frc = (m_starve == STARVE_MAX) && (mq.size() > 0);
        chk_all(!frc);
        src = -1;
        g   = '{addr: r0a, data: r0d, pc: r0p};
        if (frc || (!r0v && mq.size() > 0)) begin
            src = 1;
            g   = mq[0];
        end else if (r0v) begin
            src = 0;
        end
        push = r1v && (mq.size() != FIFO_DEPTH);
        @(posedge clk);
        m_rfwr = (src >= 0) && (g.addr != 5'd0);
        if (m_rfwr) begin
            m_a3  = g.addr;
            m_wd  = g.data;
            m_wpc = g.pc;
        end
        if (mq.size() > 0 && src != 1) m_starve = (m_starve < STARVE_MAX) ? m_starve + 1 : STARVE_MAX;
        else m_starve = 0;
        if (src == 1) void'(mq.pop_front());
        if (push) mq.push_back('{addr: r1a, data: r1d, pc: r1p});
        last_push = push;
        @(negedge clk);
        #1;
    endtask

    task automatic idle(input logic [4:0] qa);
        cycle(0, 5'd0, 32'h0, 32'h0, 0, 5'd0, 32'h0, 32'h0, qa, 5'd0);
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        #1;
        model_clear();
        for (int i = 0; i < n; i++) begin
            chk_all(1'b1);
            @(negedge clk);
            #1;
        end
        rst_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        bus.r0_valid = 1'b1; bus.r0_addr = 5'd9; bus.r0_data = 32'hDEAD0009; bus.r0_pc = 32'h100;
        bus.r1_valid = 1'b0; bus.r1_addr = 5'd0; bus.r1_data = 32'h0; bus.r1_pc = 32'h0;
        bus.q1_addr = 5'd9; bus.q2_addr = 5'd0;
        model_clear();
        @(negedge clk);
        #1;
        // Reset held with r0 requesting: nothing written, queue empty
        do_reset(3);
        cycle(1, 5'd9, 32'hDEAD0009, 32'h100, 0, 5'd0, 32'h0, 32'h0, 5'd9, 5'd0);
        // r0 only
        cycle(1, 5'd5, 32'h12345678, 32'h3000, 0, 5'd0, 32'h0, 32'h0, 5'd5, 5'd9);
        idle(5'd5);
        chk("r0_only_A3", 32'(bus.A3), 32'd5);
        // r1 push with r0 idle, watching $8
        cycle(0, 5'd0, 32'h0, 32'h0, 1, 5'd8, 32'hA, 32'h4000, 5'd8, 5'd0);
        idle(5'd8);
        idle(5'd8);
        idle(5'd8);
        // r0 saturated with one queued r1 entry: four denials then a forced grant
        cycle(1, 5'd1, 32'h11, 32'h5000, 1, 5'd12, 32'hB, 32'h5004, 5'd12, 5'd1);
        for (int i = 0; i < 7; i++)
            cycle(1, 5'(2 + i), 32'h20 + 32'(i), 32'h5100 + 32'(4 * i), 0, 5'd0, 32'h0, 32'h0, 5'd12, 5'd2);
        // Fill the queue under r0 pressure, then hold a third push until room appears
        cycle(1, 5'd3, 32'h33, 32'h6000, 1, 5'd20, 32'hC0, 32'h6004, 5'd20, 5'd21);
        cycle(1, 5'd4, 32'h44, 32'h6008, 1, 5'd21, 32'hC1, 32'h600C, 5'd20, 5'd21);
        chk("fill_r1_ready", 32'(bus.r1_ready), 32'd0);
        for (int i = 0; i < 10; i++) begin
            cycle(1, 5'd6, 32'h66, 32'h6100, 1, 5'd22, 32'hC2, 32'h6010, 5'd22, 5'd21);
            if (last_push) break;
        end
        chk("held_push_accepted", 32'(last_push), 32'd1);
        for (int i = 0; i < 8; i++) idle(5'd22);
        // Write to $0 is consumed without a register-file write
        cycle(1, 5'd0, 32'hFFFFFFFF, 32'h7000, 0, 5'd0, 32'h0, 32'h0, 5'd0, 5'd0);
        idle(5'd0);
        chk("zero_addr_RFWr", 32'(bus.RFWr), 32'd0);
        // Randomized traffic with occasional mid-operation resets
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                do_reset(1);
            end else begin
                cycle($urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom, $urandom,
                      $urandom_range(0, 2) == 0, 5'($urandom_range(0, 7)), $urandom, $urandom,
                      5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
            end
        end
        for (int i = 0; i < 8; i++) idle(5'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
